// File: rtl/dds2note_pkg.sv
// dds2note_pkg
// Shared constants and types for the DDS phase-increment to MIDI note
// converter and for any forward (note -> increment) converter reusing the
// same increment table.
//   TBL          : top-octave (octave 10) phase increments for the 12 semitones
//   TOP_OCT      : highest octave index; an octave's shift is TOP_OCT - oct
//   TOP_K_LIMIT  : highest semitone present in octave 10 (note 127 = 10*12+7)
//   LAST_K       : highest semitone index in any full octave
//   state_e      : converter FSM encoding
package dds2note_pkg;

  localparam int NUM_SEMI = 12;

  localparam logic [31:0] TBL [NUM_SEMI] = '{
    32'd359575, 32'd380957, 32'd403610, 32'd427610,
    32'd453037, 32'd479976, 32'd508516, 32'd538754,
    32'd570790, 32'd604731, 32'd640691, 32'd678788
  };

  localparam logic [3:0] TOP_OCT     = 4'd10;
  localparam logic [3:0] TOP_K_LIMIT = 4'd7;
  localparam logic [3:0] LAST_K      = 4'd11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OCT  = 2'd1,
    SEMI = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/dds2note_inc_rom.sv
// dds_inc_rom
// Combinational increment lookup: returns TBL[k] >> shift, i.e. the phase
// increment of semitone k in octave (TOP_OCT - shift). Shared with the
// forward converter so both directions use one table.
//   k_i     : semitone index 0..11 (12..15 are never addressed; they yield 0)
//   shift_i : right shift 0..10
//   inc_o   : 32-bit unsigned increment
module dds_inc_rom
  import dds2note_pkg::*;
(
  input  logic [3:0]  k_i,
  input  logic [3:0]  shift_i,
  output logic [31:0] inc_o
);

  logic [31:0] base;

  // Out-of-table indices return zero so the lookup stays fully defined.
  always_comb begin
    base = '0;
    if (k_i < 4'd12) begin
      base = TBL[k_i];
    end
    inc_o = base >> shift_i;
  end

endmodule

// File: rtl/dds2note.sv
// dds2note
// Classifies a DDS phase increment into the highest MIDI note whose
// increment does not exceed it. A coarse search walks the octaves downward
// from 10 comparing against the octave's C increment, then a fine search
// walks the semitones downward inside the hit octave. One compare per cycle.
//   CLK      : clock, all state on rising edge
//   RST_N    : asynchronous active-low reset
//   ADDER_IN : phase increment, latched on an accepted START
//   START    : request, only sampled while idle
//   BUSY     : high whenever a search is in progress or completing
//   VALID    : one-cycle result strobe
//   NOTE     : resolved note 0..127, held until the next VALID
//   UNDER    : input below the note-0 increment, held with NOTE
module dds2note
  import dds2note_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] ADDER_IN,
  input  logic        START,
  output logic        BUSY,
  output logic        VALID,
  output logic [6:0]  NOTE,
  output logic        UNDER
);

  state_e      state_q, state_d;
  logic [31:0] adder_q, adder_d;
  logic [3:0]  oct_q, oct_d;
  logic [3:0]  k_q, k_d;
  logic [6:0]  note_q, note_d;
  logic        under_q, under_d;

  logic [3:0]  romK;
  logic [3:0]  romShift;
  logic [31:0] romInc;
  logic        hit;
  logic [6:0]  noteCalc;

  // The octave search always compares against semitone 0 of the octave.
  assign romK     = (state_q == SEMI) ? k_q : 4'd0;
  assign romShift = TOP_OCT - oct_q;

  dds_inc_rom u_rom (
    .k_i     (romK),
    .shift_i (romShift),
    .inc_o   (romInc)
  );

  assign hit      = (adder_q >= romInc);
  assign noteCalc = 7'(oct_q) * 7'd12 + 7'(k_q);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      adder_q <= '0;
      oct_q   <= '0;
      k_q     <= '0;
      note_q  <= '0;
      under_q <= 1'b0;
    end else begin
      state_q <= state_d;
      adder_q <= adder_d;
      oct_q   <= oct_d;
      k_q     <= k_d;
      note_q  <= note_d;
      under_q <= under_d;
    end
  end

  // Octave 10 only holds semitones 0..7, so the fine search starts lower
  // there. Semitone 0 always hits because the octave compare already did.
  always_comb begin
    state_d = state_q;
    adder_d = adder_q;
    oct_d   = oct_q;
    k_d     = k_q;
    note_d  = note_q;
    under_d = under_q;
    unique case (state_q)
      IDLE: begin
        if (START) begin
          adder_d = ADDER_IN;
          oct_d   = TOP_OCT;
          state_d = OCT;
        end
      end
      OCT: begin
        if (hit) begin
          k_d     = (oct_q == TOP_OCT) ? TOP_K_LIMIT : LAST_K;
          state_d = SEMI;
        end else if (oct_q != 4'd0) begin
          oct_d = oct_q - 4'd1;
        end else begin
          note_d  = '0;
          under_d = 1'b1;
          state_d = DONE;
        end
      end
      SEMI: begin
        if (hit || (k_q == 4'd0)) begin
          note_d  = noteCalc;
          under_d = 1'b0;
          state_d = DONE;
        end else begin
          k_d = k_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign BUSY  = (state_q != IDLE);
  assign VALID = (state_q == DONE);
  assign NOTE  = note_q;
  assign UNDER = under_q;

endmodule

// File: doc/dds2note.md
DDS2NOTE -- requirements
Module: dds2note

Interface
REQ-001 Ports SHALL be `CLK  in  1`: system clock, all state on rising edge.
REQ-002 Ports SHALL include `RST_N  in  1`: reset, asynchronous, active-low.
REQ-003 Ports SHALL include `ADDER_IN  in  32`: DDS phase increment to classify.
REQ-004 Ports SHALL include `START  in  1`: request; sampled only in IDLE.
REQ-005 Ports SHALL include `BUSY  out  1`: high in every state except IDLE.
REQ-006 Ports SHALL include `VALID  out  1`: one-cycle result strobe.
REQ-007 Ports SHALL include `NOTE  out  7`: resolved MIDI note 0..127, held until next VALID.
REQ-008 Ports SHALL include `UNDER  out  1`: ADDER_IN below note 0 increment, held with NOTE.

Function
REQ-009 Forward map SHALL be inc(n) = TBL[n mod 12] >> (10 - n/12), n = 0..127.
REQ-010 TBL SHALL hold 359575, 380957, 403610, 427610, 453037, 479976, 508516, 538754, 570790, 604731, 640691, 678788.
REQ-011 Result SHALL be the largest n with inc(n) <= ADDER_IN, UNDER=0.
REQ-012 If ADDER_IN < inc(0)=351, result SHALL be NOTE=0, UNDER=1.
REQ-013 START high in IDLE at edge E0 SHALL latch ADDER_IN, set oct=10 and enter OCT.
REQ-014 Later changes on ADDER_IN SHALL NOT affect the running search.
REQ-015 START while BUSY SHALL be ignored and SHALL NOT be queued.
REQ-016 OCT SHALL do one compare per cycle: latched >= TBL[0]>>(10-oct).
REQ-017 On an OCT hit, FSM SHALL enter SEMI with k=7 if oct=10, else k=11.
REQ-018 On an OCT miss with oct>0, oct SHALL decrement and OCT continues.
REQ-019 On an OCT miss with oct=0, FSM SHALL enter DONE with UNDER=1.
REQ-020 SEMI SHALL do one compare per cycle: latched >= TBL[k]>>(10-oct).
REQ-021 On a SEMI hit, NOTE SHALL take oct*12+k, UNDER=0, FSM to DONE; on a miss k SHALL decrement. k=0 always hits.
REQ-022 DONE SHALL assert VALID for exactly one cycle, then return to IDLE.
REQ-023 Latency: with N total compares, VALID SHALL be high in the cycle after edge E(N).
REQ-024 N SHALL lie in 2..23.
REQ-025 Shift amounts SHALL be 0..10 and compares SHALL be 32-bit unsigned.
REQ-026 TBL indices 12..15 SHALL never be addressed.

Reset
REQ-027 RST_N low SHALL immediately force FSM=IDLE, BUSY=0, VALID=0, NOTE=0, UNDER=0, oct=0, k=0.
REQ-028 Reset mid-search SHALL abort it with no VALID issued.
REQ-029 After RST_N rises, the first START SHALL be accepted normally.

Structure
REQ-030 A shared package SHALL hold the TBL constants, TOP_OCT=10, the top-octave k limit 7 and the FSM state encoding (IDLE, OCT, SEMI, DONE).
REQ-031 One combinational sub-module `dds_inc_rom` SHALL be used: (k[3:0], shift[3:0]) -> TBL[k]>>shift.
REQ-032 `dds_inc_rom` SHALL be reusable by the forward converter.

Verification
REQ-033 Max input: ADDER_IN=0xFFFFFFFF -> NOTE=127, UNDER=0, N=2.
REQ-034 Octave-10 base: ADDER_IN=359575 -> NOTE=120, N=9.
REQ-035 A4 boundary: 18897 -> NOTE=69, N=9; 18896 -> NOTE=68, N=10.
REQ-036 Low boundary: 351 -> NOTE=0, UNDER=0, N=23; 350 -> NOTE=0, UNDER=1, N=11.
REQ-037 Handshake: START pulsed each cycle during a search -> only the first is served, one VALID.
REQ-038 Handshake: ADDER_IN changed mid-search -> result matches the latched value.
REQ-039 Reset: RST_N low at compare 5 of input 351 -> no VALID, outputs zero, next START for 359575 -> NOTE=120.
REQ-040 Sweep: inc(n) and inc(n)-1 for all n -> NOTE=n and the largest m with inc(m)<=inc(n)-1, or UNDER=1 when inc(n)-1 < 351.
